// File: rtl/mem_arb_pkg.sv
// Shared encodings for the program/data memory arbiter: owner tags and lock FSM states.
package mem_arb_pkg;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_CPU = 2'd1,
    HOLD_AUX = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the side
// that was not granted last wins. Output is one-hot {aux, cpu}.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic       req_cpu,
  input  logic       req_aux,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  assign gnt[0] = req_cpu & (~req_aux | (last_gnt == OWN_AUX));
  assign gnt[1] = req_aux & (~req_cpu | (last_gnt == OWN_CPU));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between CPU and an auxiliary master,
// with round-robin fairness, bounded lock sequences and tagged read return.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  aux_req,
  input  logic                  cpu_lock,
  input  logic                  aux_lock,
  input  logic                  cpu_we,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  cpu_gnt,
  output logic                  aux_gnt,
  output logic                  cpu_rvalid,
  output logic                  aux_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

  arb_state_t    state_reg, state_next;
  logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          last_gnt_reg;
  logic          rd_valid_reg;
  logic          rd_owner_reg;
  logic [1:0]    rr_gnt;
  logic          gnt_cpu, gnt_aux, keep_hold;

  rr_pick2 u_pick (
    .req_cpu  (cpu_req),
    .req_aux  (aux_req),
    .last_gnt (last_gnt_reg),
    .gnt      (rr_gnt)
  );

  always_comb begin
    gnt_cpu       = 1'b0;
    gnt_aux       = 1'b0;
    keep_hold     = 1'b0;
    state_next    = IDLE;
    hold_cnt_next = '0;
    case (state_reg)
      HOLD_CPU: begin
        if (cpu_req && cpu_lock) begin
          // Holder keeps the port until its budget runs out while AUX waits.
          if (hold_cnt_reg < MAX_CNT || !aux_req) begin
            gnt_cpu   = 1'b1;
            keep_hold = 1'b1;
          end else begin
            gnt_aux = 1'b1;
          end
        end else begin
          {gnt_aux, gnt_cpu} = rr_gnt;
        end
      end
      HOLD_AUX: begin
        if (aux_req && aux_lock) begin
          if (hold_cnt_reg < MAX_CNT || !cpu_req) begin
            gnt_aux   = 1'b1;
            keep_hold = 1'b1;
          end else begin
            gnt_cpu = 1'b1;
          end
        end else begin
          {gnt_aux, gnt_cpu} = rr_gnt;
        end
      end
      default: {gnt_aux, gnt_cpu} = rr_gnt;
    endcase

    if (keep_hold) begin
      state_next    = state_reg;
      hold_cnt_next = (hold_cnt_reg == MAX_CNT) ? MAX_CNT : hold_cnt_reg + 1'b1;
    end else if (gnt_cpu && cpu_lock) begin
      state_next    = HOLD_CPU;
      hold_cnt_next = CW'(1);
    end else if (gnt_aux && aux_lock) begin
      state_next    = HOLD_AUX;
      hold_cnt_next = CW'(1);
    end
  end

  // Grants are suppressed while reset is held so nothing reaches the memory.
  assign cpu_gnt = gnt_cpu & rst_n;
  assign aux_gnt = gnt_aux & rst_n;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_data = cpu_wdata;
    end else if (aux_gnt) begin
      mem_we   = aux_we;
      mem_addr = aux_addr;
      mem_data = aux_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      last_gnt_reg <= OWN_AUX;
      rd_valid_reg <= 1'b0;
      rd_owner_reg <= OWN_CPU;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      if (gnt_cpu) begin
        last_gnt_reg <= OWN_CPU;
      end else if (gnt_aux) begin
        last_gnt_reg <= OWN_AUX;
      end
      rd_valid_reg <= (gnt_cpu | gnt_aux) & ~mem_we;
      rd_owner_reg <= gnt_aux ? OWN_AUX : OWN_CPU;
    end
  end

  assign cpu_rvalid = rd_valid_reg & (rd_owner_reg == OWN_CPU);
  assign aux_rvalid = rd_valid_reg & (rd_owner_reg == OWN_AUX);
  assign cpu_rdata  = cpu_rvalid ? mem_in : '0;
  assign aux_rdata  = aux_rvalid ? mem_in : '0;

endmodule
